// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe SS RX shims: side-band tuser layout, header
// width and the state encoding of the side-band to in-band converter.
package ofs_fim_pcie_ss_shims_pkg;

    localparam int PCIE_SS_HDR_WIDTH = 256;

    // Per-segment vendor tuser carried alongside the data bus
    typedef struct packed {
        logic                         dm_mode;
        logic                         last_segment;
        logic                         hvalid;
        logic [PCIE_SS_HDR_WIDTH-1:0] hdr;
    } t_tuser_seg;

    typedef enum logic [1:0] {
        IDLE,
        MID,
        FLUSH
    } t_sb2ib_state;

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-S bus used between PCIe SS shims; clk/rst_n ride along for
// consumers that want them.
interface pcie_ss_axis_if
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int USER_W = $bits(t_tuser_seg)
)(
    input logic clk,
    input logic rst_n
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser_vendor;

    modport source (input clk, rst_n, tready,
                    output tvalid, tdata, tkeep, tlast, tuser_vendor);
    modport sink   (input clk, rst_n, tvalid, tdata, tkeep, tlast, tuser_vendor,
                    output tready);
endinterface

// File: rtl/ofs_fim_pcie_ss_rx_sb_to_ib.sv
// Side-band to in-band header converter for the slot-0 aligned RX stream.
// The SOP header lands in the low HDR_WIDTH bits of the first output beat
// and the payload is shifted up by HDR_WIDTH, with the top HDR_WIDTH bits of
// each input beat carried into the next output beat.
module ofs_fim_pcie_ss_rx_sb_to_ib
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int HDR_WIDTH   = PCIE_SS_HDR_WIDTH
)(
    input  logic           clk,
    input  logic           rst,
    pcie_ss_axis_if.sink   stream_in,
    pcie_ss_axis_if.source stream_out,
    output logic           err_no_sop
);
    localparam int HDR_BYTES   = HDR_WIDTH / 8;
    localparam int SPLIT       = TDATA_WIDTH - HDR_WIDTH;
    localparam int SPLIT_BYTES = SPLIT / 8;
    localparam int KEEP_W      = TDATA_WIDTH / 8;

    t_sb2ib_state            r_state;
    t_sb2ib_state            w_next_state;
    logic [HDR_WIDTH-1:0]    r_carry;
    logic [HDR_BYTES-1:0]    r_carry_keep;
    logic                    r_out_valid;
    logic [TDATA_WIDTH-1:0]  r_tdata;
    logic [KEEP_W-1:0]       r_tkeep;
    logic                    r_tlast;
    t_tuser_seg              r_tuser;
    t_tuser_seg              r_sop_user;
    logic                    r_err;

    t_tuser_seg              w_in_user;
    t_tuser_seg              w_sop_user;
    logic                    w_out_space;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_carry_load;
    logic                    w_sop_load;
    logic                    w_err;
    logic [HDR_BYTES-1:0]    w_in_carry_keep;
    logic                    w_beat_last;
    t_sb2ib_state            w_beat_state;
    logic [TDATA_WIDTH-1:0]  w_nxt_data;
    logic [KEEP_W-1:0]       w_nxt_keep;
    logic                    w_nxt_last;
    t_tuser_seg              w_nxt_user;
    logic                    w_unused_ok;

    assign w_in_user       = stream_in.tuser_vendor;
    assign w_out_space     = !r_out_valid || stream_out.tready;
    assign w_in_ready      = w_out_space && (r_state != FLUSH);
    assign w_accept        = stream_in.tvalid && w_in_ready;
    assign w_in_carry_keep = stream_in.tkeep[KEEP_W-1:SPLIT_BYTES];
    assign w_unused_ok     = ^{stream_in.clk, stream_in.rst_n, stream_out.clk, stream_out.rst_n};

    // End-of-beat decision shared by IDLE and MID: leftover carry bytes on
    // the last beat force one extra FLUSH beat.
    always_comb begin
        w_beat_last  = 1'b0;
        w_beat_state = MID;
        if (stream_in.tlast) begin
            w_beat_last  = ~|w_in_carry_keep;
            w_beat_state = (|w_in_carry_keep) ? FLUSH : IDLE;
        end
    end

    // Packet-level tuser copy: header is stripped, per-beat flags set later
    always_comb begin
        w_sop_user              = w_in_user;
        w_sop_user.hdr          = '0;
        w_sop_user.hvalid       = 1'b0;
        w_sop_user.last_segment = 1'b0;
    end

    // Next-state and next output beat
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_carry_load = 1'b0;
        w_sop_load   = 1'b0;
        w_err        = 1'b0;
        w_nxt_data   = r_tdata;
        w_nxt_keep   = r_tkeep;
        w_nxt_last   = r_tlast;
        w_nxt_user   = r_tuser;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_in_user.hvalid) begin
                        w_load            = 1'b1;
                        w_carry_load      = 1'b1;
                        w_sop_load        = 1'b1;
                        w_nxt_data        = {stream_in.tdata[SPLIT-1:0], w_in_user.hdr[HDR_WIDTH-1:0]};
                        w_nxt_keep        = {stream_in.tkeep[SPLIT_BYTES-1:0], {HDR_BYTES{1'b1}}};
                        w_nxt_last        = w_beat_last;
                        w_nxt_user        = w_sop_user;
                        w_nxt_user.hvalid = 1'b1;
                        w_next_state      = w_beat_state;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            MID: begin
                // A stray hvalid here is just data; no nested SOP
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_carry_load = 1'b1;
                    w_nxt_data   = {stream_in.tdata[SPLIT-1:0], r_carry};
                    w_nxt_keep   = {stream_in.tkeep[SPLIT_BYTES-1:0], r_carry_keep};
                    w_nxt_last   = w_beat_last;
                    w_nxt_user   = r_sop_user;
                    w_next_state = w_beat_state;
                end
            end
            FLUSH: begin
                if (w_out_space) begin
                    w_load       = 1'b1;
                    w_nxt_data   = {{SPLIT{1'b0}}, r_carry};
                    w_nxt_keep   = {{SPLIT_BYTES{1'b0}}, r_carry_keep};
                    w_nxt_last   = 1'b1;
                    w_nxt_user   = r_sop_user;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        w_nxt_user.last_segment = w_nxt_last;
    end

    // Control state: FSM, carry byte enables, output valid/last, error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_carry_keep <= '0;
            r_out_valid  <= 1'b0;
            r_tlast      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err;
            if (w_carry_load)
                r_carry_keep <= w_in_carry_keep;
            else if (r_state == FLUSH && w_load)
                r_carry_keep <= '0;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_tlast     <= w_nxt_last;
            end else if (stream_out.tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Datapath registers; contents only matter while qualified by valid/state
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_tdata <= w_nxt_data;
            r_tkeep <= w_nxt_keep;
            r_tuser <= w_nxt_user;
        end
        if (w_carry_load)
            r_carry <= stream_in.tdata[TDATA_WIDTH-1:SPLIT];
        if (w_sop_load)
            r_sop_user <= w_sop_user;
    end

    assign stream_in.tready         = w_in_ready;
    assign stream_out.tvalid        = r_out_valid;
    assign stream_out.tdata         = r_tdata;
    assign stream_out.tkeep         = r_tkeep;
    assign stream_out.tlast         = r_tlast;
    assign stream_out.tuser_vendor  = r_tuser;
    assign err_no_sop               = r_err;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_sb_to_ib.sv
// Bench for the side-band to in-band converter: byte-stream reference model
// plus directed literal cases and randomized traffic with backpressure.
module tb_ofs_fim_pcie_ss_rx_sb_to_ib;
    import ofs_fim_pcie_ss_shims_pkg::*;

    localparam int DW = 512;
    localparam int HW = 256;
    localparam int UW = $bits(t_tuser_seg);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_no_sop;
    always #5 clk = ~clk;

    pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) s_in  (.clk(clk), .rst_n(~rst));
    pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) s_out (.clk(clk), .rst_n(~rst));

    ofs_fim_pcie_ss_rx_sb_to_ib #(.TDATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
        .clk(clk), .rst(rst), .stream_in(s_in), .stream_out(s_out), .err_no_sop(err_no_sop)
    );

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;

    // reference model: expected output byte stream, split per packet
    byte        exp_bytes[$];
    int         pkt_rem[$];
    bit         pkt_done[$];
    bit         pkt_first[$];
    t_tuser_seg pkt_user[$];
    bit         m_in_pkt = 0;
    logic       exp_err = 0;

    // output capture for directed cases
    logic [DW-1:0] cap_d[16];
    logic [63:0]   cap_k[16];
    logic          cap_l[16];
    t_tuser_seg    cap_u[16];
    int            cap_cnt = 0;
    int            rl_cnt = 0;

    logic          hold_v = 0;
    logic [DW-1:0] hold_d;
    logic [63:0]   hold_k;
    logic          hold_l;
    logic [UW-1:0] hold_u;

    task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] kmask(input int n);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_out();
        int n;
        bit el;
        logic [DW-1:0] ed, am;
        t_tuser_seg eu, au;
        au = s_out.tuser_vendor;
        cap_d[cap_cnt % 16] = s_out.tdata;
        cap_k[cap_cnt % 16] = s_out.tkeep;
        cap_l[cap_cnt % 16] = s_out.tlast;
        cap_u[cap_cnt % 16] = au;
        cap_cnt++;
        if (pkt_rem.size() == 0) begin
            chk(1'b0, "unexpected_out_beat", s_out.tdata, '0);
            return;
        end
        n  = (pkt_rem[0] < 64) ? pkt_rem[0] : 64;
        el = pkt_done[0] && (pkt_rem[0] <= 64);
        ed = '0;
        am = s_out.tdata;
        for (int i = 0; i < 64; i++) begin
            if (i < n) ed[8*i +: 8] = exp_bytes[i];
            else       am[8*i +: 8] = 8'h0;
        end
        chk(s_out.tkeep === kmask(n), "out_tkeep", s_out.tkeep, kmask(n));
        chk(am === ed, "out_tdata", am, ed);
        chk(s_out.tlast === el, "out_tlast", s_out.tlast, el);
        eu = pkt_user[0];
        eu.hvalid = pkt_first[0];
        eu.last_segment = el;
        chk(au === eu, "out_tuser", au, eu);
        for (int i = 0; i < n; i++) void'(exp_bytes.pop_front());
        pkt_rem[0] -= n;
        pkt_first[0] = 1'b0;
        if (el) begin
            void'(pkt_rem.pop_front());
            void'(pkt_done.pop_front());
            void'(pkt_first.pop_front());
            void'(pkt_user.pop_front());
        end
    endtask

    task automatic record_in();
        t_tuser_seg u;
        int n;
        int last;
        u = s_in.tuser_vendor;
        n = 0;
        for (int i = 0; i < 64; i++) if (s_in.tkeep[i]) n++;
        if (!m_in_pkt) begin
            if (!u.hvalid) begin
                exp_err = 1'b1;
            end else begin
                for (int j = 0; j < HW/8; j++) exp_bytes.push_back(u.hdr[8*j +: 8]);
                for (int j = 0; j < n; j++) exp_bytes.push_back(s_in.tdata[8*j +: 8]);
                pkt_rem.push_back(HW/8 + n);
                pkt_done.push_back(s_in.tlast);
                pkt_first.push_back(1'b1);
                u.hdr = '0;
                u.hvalid = 1'b0;
                u.last_segment = 1'b0;
                pkt_user.push_back(u);
                m_in_pkt = !s_in.tlast;
            end
        end else begin
            last = pkt_rem.size() - 1;
            for (int j = 0; j < n; j++) exp_bytes.push_back(s_in.tdata[8*j +: 8]);
            pkt_rem[last] += n;
            if (s_in.tlast) begin
                pkt_done[last] = 1'b1;
                m_in_pkt = 1'b0;
            end
        end
    endtask

    // compare process: outputs, hold stability and error pulse every cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_bytes.delete(); pkt_rem.delete(); pkt_done.delete();
            pkt_first.delete(); pkt_user.delete();
            m_in_pkt = 1'b0;
            exp_err = 1'b0;
            hold_v = 1'b0;
        end else begin
            chk(err_no_sop === exp_err, "err_no_sop", err_no_sop, exp_err);
            if (hold_v)
                chk(s_out.tvalid === 1'b1 && s_out.tdata === hold_d && s_out.tkeep === hold_k &&
                    s_out.tlast === hold_l && s_out.tuser_vendor === hold_u,
                    "out_hold_stable", s_out.tdata, hold_d);
            hold_v = s_out.tvalid && !s_out.tready;
            hold_d = s_out.tdata;
            hold_k = s_out.tkeep;
            hold_l = s_out.tlast;
            hold_u = s_out.tuser_vendor;
            if (s_out.tvalid === 1'b1 && s_out.tready) check_out();
            if (!s_in.tready) rl_cnt++;
            exp_err = 1'b0;
            if (s_in.tvalid && s_in.tready) record_in();
        end
    end

    // random output backpressure
    initial begin
        s_out.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            s_out.tready = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // drive one beat and hold it until accepted (entered at posedge+1)
    task automatic send_beat(input logic [DW-1:0] d, input logic [63:0] k, input bit last, input t_tuser_seg u);
        bit ok;
        int tries = 0;
        s_in.tvalid = 1'b1;
        s_in.tdata = d;
        s_in.tkeep = k;
        s_in.tlast = last;
        s_in.tuser_vendor = u;
        do begin
            @(negedge clk); ok = s_in.tready;
            @(posedge clk); #1;
            tries++;
        end while (!ok && tries < 2000);
        if (!ok) chk(1'b0, "in_handshake_timeout", tries, 2000);
        s_in.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        int nb, cnt;
        logic [HW-1:0] h;
        t_tuser_seg u;
        logic [DW-1:0] r;
        r = rnd512();
        h = r[HW-1:0];
        nb = (n == 0) ? 1 : (n + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
            cnt = n - 64*b;
            if (cnt > 64) cnt = 64;
            r = rnd512();
            u.dm_mode = $urandom_range(1);
            u.last_segment = $urandom_range(1);
            if (b == 0) begin
                u.hvalid = 1'b1;
                u.hdr = h;
            end else begin
                u.hvalid = $urandom_range(1);
                u.hdr = r[DW-1:HW];
            end
            send_beat(rnd512(), kmask(cnt), (b == nb - 1), u);
        end
    endtask

    initial begin : main
        t_tuser_seg u;
        logic [HW-1:0] h, p;
        logic [DW-1:0] d, r;
        int base, rbase, t;

        s_in.tvalid = 1'b0;
        s_in.tdata = '0;
        s_in.tkeep = '0;
        s_in.tlast = 1'b0;
        s_in.tuser_vendor = '0;
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        chk(s_out.tvalid === 1'b0, "reset_out_tvalid", s_out.tvalid, 0);
        chk(s_in.tready === 1'b1, "reset_in_tready", s_in.tready, 1);
        chk(err_no_sop === 1'b0, "reset_err", err_no_sop, 0);
        chk(s_out.tlast === 1'b0, "reset_out_tlast", s_out.tlast, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_pct = 100;
        idle(2);

        // header-only packet
        r = rnd512(); h = r[HW-1:0];
        u = '0; u.hvalid = 1'b1; u.hdr = h; u.dm_mode = 1'b1;
        base = cap_cnt;
        send_beat(rnd512(), 64'h0, 1'b1, u);
        idle(4);
        chk(cap_cnt - base == 1, "hdr_only_beats", cap_cnt - base, 1);
        chk(cap_d[base % 16][HW-1:0] === h, "hdr_only_data", cap_d[base % 16][HW-1:0], h);
        chk(cap_k[base % 16] === 64'h0000_0000_FFFF_FFFF, "hdr_only_keep", cap_k[base % 16], 64'h0000_0000_FFFF_FFFF);
        chk(cap_l[base % 16] === 1'b1 && cap_u[base % 16].hvalid === 1'b1 && cap_u[base % 16].hdr === '0 &&
            cap_u[base % 16].last_segment === 1'b1 && cap_u[base % 16].dm_mode === 1'b1,
            "hdr_only_flags", cap_u[base % 16], 0);

        // 32-byte payload
        r = rnd512(); h = r[HW-1:0]; p = r[DW-1:HW];
        d = rnd512(); d[HW-1:0] = p;
        u = '0; u.hvalid = 1'b1; u.hdr = h;
        base = cap_cnt;
        send_beat(d, 64'h0000_0000_FFFF_FFFF, 1'b1, u);
        idle(4);
        chk(cap_cnt - base == 1, "p32_beats", cap_cnt - base, 1);
        chk(cap_d[base % 16] === {p, h}, "p32_data", cap_d[base % 16], {p, h});
        chk(cap_k[base % 16] === 64'hFFFF_FFFF_FFFF_FFFF, "p32_keep", cap_k[base % 16], 64'hFFFF_FFFF_FFFF_FFFF);
        chk(cap_l[base % 16] === 1'b1, "p32_last", cap_l[base % 16], 1);

        // 64-byte payload: one FLUSH beat, one input bubble
        r = rnd512(); h = r[HW-1:0];
        d = rnd512();
        u = '0; u.hvalid = 1'b1; u.hdr = h;
        base = cap_cnt;
        rbase = rl_cnt;
        send_beat(d, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, u);
        idle(4);
        chk(cap_cnt - base == 2, "p64_beats", cap_cnt - base, 2);
        chk(cap_d[base % 16] === {d[HW-1:0], h}, "p64_b0_data", cap_d[base % 16], {d[HW-1:0], h});
        chk(cap_k[base % 16] === 64'hFFFF_FFFF_FFFF_FFFF && cap_l[base % 16] === 1'b0, "p64_b0_keep_last",
            {cap_k[base % 16], cap_l[base % 16]}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        chk(cap_d[(base+1) % 16] === {{HW{1'b0}}, d[DW-1:HW]}, "p64_b1_data", cap_d[(base+1) % 16], {{HW{1'b0}}, d[DW-1:HW]});
        chk(cap_k[(base+1) % 16] === 64'h0000_0000_FFFF_FFFF && cap_l[(base+1) % 16] === 1'b1, "p64_b1_keep_last",
            {cap_k[(base+1) % 16], cap_l[(base+1) % 16]}, {64'h0000_0000_FFFF_FFFF, 1'b1});
        chk(rl_cnt - rbase == 1, "p64_ready_low_cycles", rl_cnt - rbase, 1);

        // missing SOP in IDLE
        u = '0; u.hvalid = 1'b0;
        base = cap_cnt;
        send_beat(rnd512(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, u);
        @(negedge clk);
        chk(err_no_sop === 1'b1, "nosop_err_pulse", err_no_sop, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk(err_no_sop === 1'b0, "nosop_err_width", err_no_sop, 0);
        @(posedge clk); #1;
        idle(2);
        chk(cap_cnt == base, "nosop_no_output", cap_cnt - base, 0);

        // reset while in MID, then a clean packet
        u = '0; u.hvalid = 1'b1; r = rnd512(); u.hdr = r[HW-1:0];
        send_beat(rnd512(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, u);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(s_out.tvalid === 1'b0, "rst_mid_tvalid", s_out.tvalid, 0);
        chk(s_in.tready === 1'b1, "rst_mid_tready", s_in.tready, 1);
        @(posedge clk); #1;
        send_pkt(150);
        idle(6);

        // random traffic under backpressure
        for (int k = 0; k < 100; k++) begin
            rdy_pct = $urandom_range(40, 100);
            send_pkt($urandom_range(0, 256));
        end
        rdy_pct = 100;
        t = 0;
        while (pkt_rem.size() != 0 && t < 2000) begin
            @(posedge clk); t++;
        end
        #1;
        chk(pkt_rem.size() == 0, "drain_all_packets", pkt_rem.size(), 0);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
